stack_lifo_mem: RTL and testbench
=================================

Name: stack_lifo_mem

Overview:
- Operand stack that answers the push/pop requests issued by the calculator memory controller.
- Stores 32-bit words in LIFO order and always presents the current top-of-stack on memOut.
- Exposes occupancy, full/empty status and sticky error flags for LEDs and the seven-segment display.
- Offers a second read-only peek port so the display logic can show any stack entry without disturbing it.

Parameters:
- DATA_W, 32, width of each stack word.
- DEPTH, 16, number of entries; must be a power of 2, minimum 2.
- AW, $clog2(DEPTH), pointer/index width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- push  input  1  write memIn as new top this cycle (level; one word per cycle asserted).
- pop  input  1  remove top entry this cycle.
- memIn  input  DATA_W  data to push.
- clr_err  input  1  synchronous clear of overflow/underflow flags.
- peek_idx  input  AW  depth below top to read (0 = top).
- memOut  output  DATA_W  current top-of-stack; 0 when empty.
- peek_data  output  DATA_W  entry at peek_idx; 0 if peek_idx >= count.
- count  output  AW+1  number of valid entries, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky: push attempted while full.
- underflow  output  1  sticky: pop attempted while empty.

Behaviour:
- Reset (async, rst low):
  - sp, count = 0; overflow, underflow = 0.
  - memOut, peek_data = 0 (stack is empty).
  - Storage array is not cleared.
  - Reset mid-operation discards all contents immediately; first clock after release is a normal cycle.
- State:
  - Registered stack pointer sp (AW+1 bits) equals count.
  - Storage array mem[0..DEPTH-1]; mem[sp-1] is the top.
- Read timing:
  - memOut = mem[sp-1] when sp != 0, else 0.
  - Combinational from registered state, so it reflects a push/pop on the very next cycle after the edge that performed it.
  - The controller's pop / wait / read sequence therefore sees the new top one cycle later.
- Per rising edge, evaluated in priority order:
  - push & pop & !empty: overwrite mem[sp-1] with memIn; sp unchanged (replace-top).
  - push & pop & empty: treated as a plain push; no underflow.
  - push only, !full: mem[sp] <= memIn; sp <= sp+1.
  - push only, full: no write, sp unchanged; overflow <= 1.
  - pop only, !empty: sp <= sp-1; the data word is left in the array.
  - pop only, empty: sp unchanged; underflow <= 1.
  - neither: hold.
- Error flags:
  - Sticky until clr_err or reset.
  - If clr_err coincides with a new error event, the set wins.
- Peek port:
  - peek_data = mem[sp-1-peek_idx] if peek_idx < sp, else 0.
  - Purely combinational; does not affect state.
- Arithmetic:
  - sp never wraps; it saturates logically at 0 and DEPTH via the full/empty guards.
  - Array addressing uses the low AW bits of sp.
- Status:
  - empty and full are combinational decodes of sp.
  - Both are valid from reset.

Decomposition:
- Shared package (calc_pkg):
  - CALC_DATA_W = 32.
  - CALC_STACK_DEPTH = 16.
  - Neither block hard-codes widths.
- One sub-module, stack_regfile: DEPTH x DATA_W register array with one synchronous write port and two asynchronous read ports (top, peek).
  - The pointer/flag logic stays in stack_lifo_mem.

Test Plan:
- Reset, then push 0x5 and 0x3 on consecutive cycles:
  - count = 2, memOut = 0x3, peek_idx = 1 gives 0x5.
  - Pop once: memOut = 0x5, count = 1.
- Controller-style sequence on stack [0x5, 0x3]:
  - Stimulus: pop, idle, pop, idle, push 0x8 (pops one cycle apart).
  - Required: memOut 0x3 before the first pop, 0x5 after it; after the push, count = 1 and memOut = 0x8.
- Fill DEPTH = 16 entries, then push 0xDEAD:
  - full = 1, count = 16, memOut unchanged, overflow = 1.
  - Pulse clr_err: overflow = 0.
- On an empty stack, pop:
  - underflow = 1, count = 0, memOut = 0.
  - Then push & pop together with memIn = 0x7: count = 1, memOut = 0x7, underflow still 1.
- Stack [0x1, 0x2], push & pop with memIn = 0x9:
  - count = 2, memOut = 0x9, peek_idx = 1 gives 0x1.
  - peek_idx = 2 gives 0.
- Push 3 words, assert rst low asynchronously mid-cycle:
  - count, memOut, flags go to 0 immediately.
  - After release, push 0xA gives count = 1, memOut = 0xA.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: word width and stack depth shared by the calculator stack blocks
package calc_pkg;
    localparam int CALC_DATA_W = 32;
    localparam int CALC_STACK_DEPTH = 16;
endpackage

// File: rtl/stack_regfile.sv
// stack_regfile: stack storage, one synchronous write port and asynchronous top/peek reads
module stack_regfile
    import calc_pkg::*;
#(
    parameter int DATA_W = CALC_DATA_W,
    parameter int DEPTH = CALC_STACK_DEPTH,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr_top,
    input  logic [AW-1:0]     raddr_peek,
    output logic [DATA_W-1:0] rdata_top,
    output logic [DATA_W-1:0] rdata_peek
);
    logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata_top = mem[raddr_top];
    assign rdata_peek = mem[raddr_peek];
endmodule

// File: rtl/stack_lifo_mem.sv
// stack_lifo_mem: LIFO operand stack with top-of-stack output, peek port and sticky error flags
module stack_lifo_mem
    import calc_pkg::*;
#(
    parameter int DATA_W = CALC_DATA_W,
    parameter int DEPTH = CALC_STACK_DEPTH,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] memIn,
    input  logic              clr_err,
    input  logic [AW-1:0]     peek_idx,
    output logic [DATA_W-1:0] memOut,
    output logic [DATA_W-1:0] peek_data,
    output logic [AW:0]       count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);
    localparam logic [AW:0] ONE = (AW+1)'(1);
    logic [AW:0] sp;
    logic [AW-1:0] top_idx, peek_addr, waddr;
    logic [DATA_W-1:0] top_rd, peek_rd;
    logic replace, we, ovf_evt, unf_evt;
    assign empty = sp == '0;
    assign full = sp == (AW+1)'(DEPTH);
    assign count = sp;
    assign top_idx = sp[AW-1:0] - AW'(1);
    assign peek_addr = top_idx - peek_idx;
    // push and pop together on a non-empty stack rewrites the top in place
    assign replace = push & pop & ~empty;
    assign we = replace | (push & ~full);
    assign waddr = replace ? top_idx : sp[AW-1:0];
    assign ovf_evt = push & ~pop & full;
    assign unf_evt = pop & ~push & empty;
    assign memOut = empty ? '0 : top_rd;
    assign peek_data = ({1'b0, peek_idx} < sp) ? peek_rd : '0;
    stack_regfile #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_regfile (
        .clk(clk),
        .we(we),
        .waddr(waddr),
        .wdata(memIn),
        .raddr_top(top_idx),
        .raddr_peek(peek_addr),
        .rdata_top(top_rd),
        .rdata_peek(peek_rd)
    );
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            sp <= '0;
            overflow <= 1'b0;
            underflow <= 1'b0;
        end else begin
            sp <= (push & ~pop & ~full) | (push & pop & empty) ? sp + ONE :
                  (pop & ~push & ~empty) ? sp - ONE : sp;
            overflow <= ovf_evt | (overflow & ~clr_err);
            underflow <= unf_evt | (underflow & ~clr_err);
        end
endmodule

// File: tb/tb_stack_lifo_mem.sv
// tb_stack_lifo_mem: scoreboard bench for stack_lifo_mem against a queue-based stack model
module tb_stack_lifo_mem;
    localparam int DW = 32;
    localparam int D = 16;
    localparam int AW = $clog2(D);
    typedef struct {
        logic [DW-1:0] top;
        logic [DW-1:0] peek;
        int cnt;
        logic ovf;
        logic unf;
    } exp_t;
    logic clk = 1'b0, rst = 1'b0, push = 1'b0, pop = 1'b0, clr_err = 1'b0;
    logic [DW-1:0] memIn = '0;
    logic [AW-1:0] peek_idx = '0;
    logic [DW-1:0] memOut, peek_data;
    logic [AW:0] count;
    logic empty, full, overflow, underflow;
    logic [DW-1:0] mstk [$];
    logic movf = 1'b0, munf = 1'b0;
    exp_t exp_q [$];
    int n_checks = 0, n_err = 0;

    stack_lifo_mem dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .memIn(memIn), .clr_err(clr_err),
        .peek_idx(peek_idx), .memOut(memOut), .peek_data(peek_data), .count(count),
        .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_peek(input int idx);
        return idx < mstk.size() ? mstk[mstk.size() - 1 - idx] : '0;
    endfunction

    task automatic compare_outputs();
        exp_t e;
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check("top", memOut, e.top);
        check("peek", peek_data, e.peek);
        check("count", DW'(count), DW'(e.cnt));
        check("empty", DW'(empty), DW'(e.cnt == 0));
        check("full", DW'(full), DW'(e.cnt == D));
        check("ovf", DW'(overflow), DW'(e.ovf));
        check("unf", DW'(underflow), DW'(e.unf));
    endtask

    task automatic cyc(input logic p, input logic q, input logic [DW-1:0] d, input logic c);
        exp_t e;
        bit me, mf;
        push = p; pop = q; memIn = d; clr_err = c;
        me = mstk.size() == 0;
        mf = mstk.size() == D;
        if (c) begin movf = 1'b0; munf = 1'b0; end
        if (p && q && !me) mstk[mstk.size() - 1] = d;
        else if (p && !mf) mstk.push_back(d);
        else if (p) movf = 1'b1;
        else if (q && !me) void'(mstk.pop_back());
        else if (q) munf = 1'b1;
        e.top = model_peek(0);
        e.peek = model_peek(int'(peek_idx));
        e.cnt = mstk.size();
        e.ovf = movf;
        e.unf = munf;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; clr_err = 1'b0;
        compare_outputs();
    endtask

    task automatic drain();
        while (mstk.size() > 0) cyc(0, 1, '0, 0);
    endtask

    initial begin
        #12;
        check("rst_count", DW'(count), 0);
        check("rst_top", memOut, 0);
        check("rst_empty", DW'(empty), 1);
        check("rst_full", DW'(full), 0);
        check("rst_peek", peek_data, 0);
        rst = 1'b1;
        // basic push/peek/pop
        cyc(1, 0, 32'h5, 0);
        cyc(1, 0, 32'h3, 0);
        check("t1_count", DW'(count), 2);
        check("t1_top", memOut, 32'h3);
        peek_idx = 1;
        #1 check("t1_peek1", peek_data, 32'h5);
        peek_idx = 0;
        cyc(0, 1, '0, 0);
        check("t1_pop_top", memOut, 32'h5);
        check("t1_pop_count", DW'(count), 1);
        // controller pop/idle sequence
        cyc(1, 0, 32'h3, 0);
        check("t2_pre", memOut, 32'h3);
        cyc(0, 1, '0, 0);
        check("t2_pop1", memOut, 32'h5);
        cyc(0, 0, '0, 0);
        cyc(0, 1, '0, 0);
        cyc(0, 0, '0, 0);
        cyc(1, 0, 32'h8, 0);
        check("t2_count", DW'(count), 1);
        check("t2_top", memOut, 32'h8);
        // fill and overflow
        drain();
        for (int i = 0; i < D; i++) cyc(1, 0, 32'h100 + i, 0);
        cyc(1, 0, 32'hDEAD, 0);
        check("t3_full", DW'(full), 1);
        check("t3_count", DW'(count), D);
        check("t3_top", memOut, 32'h10F);
        check("t3_ovf", DW'(overflow), 1);
        cyc(0, 0, '0, 1);
        check("t3_clr", DW'(overflow), 0);
        // underflow, then push&pop on empty
        drain();
        cyc(0, 1, '0, 0);
        check("t4_unf", DW'(underflow), 1);
        check("t4_count", DW'(count), 0);
        check("t4_top", memOut, 0);
        cyc(1, 1, 32'h7, 0);
        check("t4_pp_count", DW'(count), 1);
        check("t4_pp_top", memOut, 32'h7);
        check("t4_pp_unf", DW'(underflow), 1);
        cyc(0, 1, '0, 1);
        // replace top
        cyc(1, 0, 32'h1, 0);
        cyc(1, 0, 32'h2, 0);
        cyc(1, 1, 32'h9, 0);
        check("t5_count", DW'(count), 2);
        check("t5_top", memOut, 32'h9);
        peek_idx = 1;
        #1 check("t5_peek1", peek_data, 32'h1);
        peek_idx = 2;
        #1 check("t5_peek2", peek_data, 0);
        peek_idx = 0;
        // random traffic, clr_err coincident with events included
        for (int i = 0; i < 400; i++) begin
            peek_idx = AW'($urandom_range(D - 1));
            cyc(1'($urandom_range(1)), 1'($urandom_range(1)), $urandom, 1'($urandom_range(7) == 0));
        end
        // async reset mid-cycle
        drain();
        cyc(0, 0, '0, 1);
        for (int i = 0; i < 3; i++) cyc(1, 0, 32'h40 + i, 0);
        #2 rst = 1'b0;
        #1;
        check("t6_count", DW'(count), 0);
        check("t6_top", memOut, 0);
        check("t6_ovf", DW'(overflow), 0);
        check("t6_unf", DW'(underflow), 0);
        check("t6_empty", DW'(empty), 1);
        mstk.delete();
        movf = 1'b0;
        munf = 1'b0;
        #1 rst = 1'b1;
        cyc(1, 0, 32'hA, 0);
        check("t6_count_after", DW'(count), 1);
        check("t6_top_after", memOut, 32'hA);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
